regbank: RTL and testbench



---
 rtl/regbank.sv | 33 +++
 tb/tb_regbank.sv | 110 +++++++++++
 2 files changed

// File: rtl/regbank.sv
// regbank: 32x32 2R1W register file, r0 hardwired 0; in clk reset write dr wrData sr1 sr2, out rdData1 rdData2; `REGBANK_BYPASS_EN enables write-through forwarding
module regbank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] dr,
  input  logic [DATA_WIDTH-1:0] wrData,
  input  logic [ADDR_WIDTH-1:0] sr1,
  input  logic [ADDR_WIDTH-1:0] sr2,
  output logic [DATA_WIDTH-1:0] rdData1,
  output logic [DATA_WIDTH-1:0] rdData2
);
  logic [DATA_WIDTH-1:0] r [2**ADDR_WIDTH];
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < 2**ADDR_WIDTH; i++) r[i] <= '0;
    else if (write && dr != '0) r[dr] <= wrData;
`ifdef REGBANK_BYPASS_EN
  logic fwd;
  always_comb begin
    fwd = !reset && write && dr != '0;
    rdData1 = fwd && dr == sr1 ? wrData : r[sr1];
    rdData2 = fwd && dr == sr2 ? wrData : r[sr2];
  end
`else
  always_comb begin
    rdData1 = r[sr1];
    rdData2 = r[sr2];
  end
`endif
endmodule

// File: tb/tb_regbank.sv
`timescale 1ns/1ps
module tb_regbank;
  logic clk = 0, reset = 1, write = 0;
  logic [4:0] dr = 0, sr1 = 0, sr2 = 0;
  logic [31:0] wrData = 0, rdData1, rdData2;
  int checks = 0, passed = 0;
  logic [31:0] m [32];
  typedef struct { logic [4:0] s1, s2; logic [31:0] e1, e2; } vec_t;
  vec_t vt [16];

  regbank dut (.clk(clk), .reset(reset), .write(write), .dr(dr), .wrData(wrData),
               .sr1(sr1), .sr2(sr2), .rdData1(rdData1), .rdData2(rdData2));

  always #50 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, got, exp);
  endtask

  task automatic clr();
    for (int i = 0; i < 32; i++) m[i] = 0;
  endtask

  task automatic all_zero(input string n);
    for (int i = 0; i < 32; i++) begin
      sr1 = i[4:0]; sr2 = 5'(31 - i); #1;
      chk({n, "_p1"}, rdData1, 0);
      chk({n, "_p2"}, rdData2, 0);
    end
  endtask

  task automatic wr(input logic [4:0] d, input logic [31:0] v, input logic en);
    @(negedge clk); write = en; dr = d; wrData = v;
    @(posedge clk); #1; write = 0;
    if (en && d != 0) m[d] = v;
  endtask

  function automatic logic [31:0] pre(input logic [4:0] s);
`ifdef REGBANK_BYPASS_EN
    return (write && dr != 0 && dr == s) ? wrData : m[s];
`else
    return m[s];
`endif
  endfunction

  initial begin
    clr();
    #20 all_zero("reset_init");
    @(negedge clk); reset = 0;

    for (int k = 0; k < 32; k++) wr(k[4:0], 32'(10 * k), 1);
    for (int k = 0; k < 32; k += 2)
      vt[k/2] = '{k[4:0], 5'(k + 1), (k == 0) ? 32'd0 : 32'(10 * k), 32'(10 * (k + 1))};
    for (int i = 0; i < 16; i++) begin
      sr1 = vt[i].s1; sr2 = vt[i].s2; #1;
      chk($sformatf("fill_r%0d", vt[i].s1), rdData1, vt[i].e1);
      chk($sformatf("fill_r%0d", vt[i].s2), rdData2, vt[i].e2);
    end

    @(negedge clk); #5 reset = 1; #1;
    all_zero("async_reset");
    #2 reset = 0; clr();

    for (int i = 0; i < 3; i++) wr(0, 20, 1);
    sr1 = 0; #1; chk("r0_hardwired", rdData1, 0);

    wr(5, 50, 1);
    for (int i = 0; i < 3; i++) wr(5, 32'hDEAD, 0);
    sr1 = 5; #1; chk("write_gate", rdData1, 50);

    wr(7, 70, 1);
    @(negedge clk); sr1 = 7; dr = 7; wrData = 99; write = 1; #1;
`ifdef REGBANK_BYPASS_EN
    chk("same_cycle_pre", rdData1, 99);
`else
    chk("same_cycle_pre", rdData1, 70);
`endif
    @(posedge clk); #1; chk("same_cycle_post", rdData1, 99);
    write = 0; m[7] = 99;

    for (int k = 1; k < 32; k++) wr(k[4:0], 32'(10 * k + 1), 1);
    @(negedge clk); write = 1; dr = 3; wrData = 32'h1234; sr1 = 3; sr2 = 3; reset = 1; #1;
    chk("reset_no_fwd1", rdData1, 0);
    chk("reset_no_fwd2", rdData2, 0);
    @(posedge clk); #1; chk("reset_write_r3", rdData1, 0);
    @(negedge clk); write = 0; reset = 0; clr();
    all_zero("reset_mid");

    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      write = 1'($urandom);
      dr = 5'($urandom);
      wrData = $urandom;
      sr1 = ($urandom_range(0, 3) == 0) ? dr : 5'($urandom);
      sr2 = ($urandom_range(0, 3) == 0) ? dr : 5'($urandom);
      #1;
      chk("rand_pre1", rdData1, pre(sr1));
      chk("rand_pre2", rdData2, pre(sr2));
      @(posedge clk); #1;
      if (write && dr != 0) m[dr] = wrData;
      chk("rand_post1", rdData1, m[sr1]);
      chk("rand_post2", rdData2, m[sr2]);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
